simple_bus_responder: RTL
=========================

# simple_bus_responder

Slave-side endpoint of the `simple_bus` protocol. It arbitrates a single master's `req` into `gnt`, accepts `start`-qualified read and write commands, and answers each one with a one-cycle `rdy` pulse after a programmable number of wait states. Commands are served from a local register-file memory. The block sits behind the `slave` modport and is the counterpart to the master's `masterRead`/`masterWrite` tasks. It serves as a bus target in system integration and as a reference responder in testbenches.

## Interface
Parameters:
- `ADDR_W`, default 8: address width; matches `simple_bus.addr`.
- `DATA_W`, default 8: data width; matches `simple_bus.data`.
- `DEPTH`, default 256: number of memory words; must be ≤ 2^ADDR_W.
- `WAIT_STATES`, default 1: cycles inserted between command acceptance and `rdy`; range 0–15.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req`, input, 1: master requests bus ownership.
- `gnt`, output, 1: ownership granted to the master.
- `start`, input, 1: one-cycle command strobe; `addr`, `mode` and `data_i` are valid with it.
- `addr`, input, ADDR_W: command address.
- `mode`, input, 2: command code (NOP/READ/WRITE/RSVD).
- `data_i`, input, DATA_W: write data, driven by the master.
- `data_o`, output, DATA_W: read data.
- `data_oe`, output, 1: responder is driving `data`; asserted only with `rdy` on a successful read.
- `rdy`, output, 1: one-cycle command-complete pulse.
- `err`, output, 1: one-cycle pulse, coincident with `rdy`, flagging an out-of-range address or RSVD mode.

## Operation
FSM states and transitions:
- IDLE: `gnt`=0. Moves to GRANTED when `req`=1.
- GRANTED: `gnt`=1.
  - `req`=0 → IDLE.
  - `start`=1 → latches `addr`, `mode` and `data_i`, then goes to WAIT, or straight to RESP when WAIT_STATES=0.
- WAIT: wait-state counter counts down to zero, then → RESP. `gnt` stays 1.
- RESP: `rdy`=1 for exactly this one cycle.
  - Next state is GRANTED if `req`=1, else IDLE.

Command effects, all using latched values:
- READ: `data_o`=mem[addr] and `data_oe`=1 in RESP.
- WRITE: mem[addr] ← `data_i` on the RESP clock edge. `data_oe`=0.
- NOP: `rdy` pulses with no side effect. `err`=0.
- RSVD (2'b11), or `addr` ≥ DEPTH: `rdy`=1 and `err`=1. Memory is unchanged. For a read, `data_o`=0 and `data_oe`=0.

Boundary conditions:
- `start` outside GRANTED (in IDLE, WAIT or RESP) is ignored, with no side effect.
- `req` deasserted while in WAIT or RESP: the command still completes, and `gnt` drops the cycle after RESP.
- `addr`, `mode` and `data_i` may change after the `start` cycle; only the latched copies are used.
- A read immediately following a write to the same address returns the new data.
- `rst_n`=0 at any point, including mid-command:
  - the FSM goes to IDLE;
  - outputs `gnt`, `rdy`, `err`, `data_oe` are cleared to 0 and `data_o` to 0;
  - memory is cleared to 0;
  - an in-flight write is discarded.

## Timing
- `gnt` is asserted in the cycle after `req` is first sampled high from IDLE (1-cycle latency).
- With `start` sampled at edge T, `rdy` is high in cycle T+1+WAIT_STATES.
- The earliest next accepted `start` is at T+2+WAIT_STATES; sustained throughput is one command per WAIT_STATES+2 cycles.
- `gnt` is released in the cycle after `req` is sampled low in GRANTED.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `simple_bus_pkg` holds:
  - `bus_mode_e` with MODE_NOP=0, MODE_READ=1, MODE_WRITE=2, MODE_RSVD=3;
  - `resp_state_e` with IDLE, GRANTED, WAIT, RESP;
  - default width constants.
- Sub-module `simple_bus_resp_mem`: a DEPTH×DATA_W array with synchronous write, combinational read, and synchronous clear.
- The top level holds the FSM, the wait counter, the command latch and the output registers.

## Test plan
- Reset, then `req`=1 → `gnt`=1 one cycle later. All other outputs are 0 throughout reset.
- With WAIT_STATES=1: WRITE addr 8'h3C, data 8'hA5 at T, then READ 8'h3C → `rdy` at T+2, then `data_o`=8'hA5 with `data_oe`=1 on the read's `rdy`.
- `start` pulsed while `gnt`=0, and again during WAIT → no `rdy`, memory unchanged.
- With DEPTH=16: READ addr 8'h20 → `rdy`=1, `err`=1, `data_o`=0, `data_oe`=0. Then `mode`=2'b11 → `err` pulses again.
- `req` dropped the cycle after `start` → `rdy` still occurs, and `gnt`=0 the cycle after `rdy`.
- `rst_n` pulsed low during WAIT of a WRITE to 8'h05 → the FSM returns to IDLE, and a later READ of 8'h05 returns 8'h00.

Source files
------------

// File: rtl/simple_bus_pkg.sv
//============================================================================
// Module : simple_bus_pkg
// Brief  : Shared types and default widths for the simple_bus responder.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package simple_bus_pkg;

    localparam int unsigned c_addr_w      = 8;
    localparam int unsigned c_data_w      = 8;
    localparam int unsigned c_depth       = 256;
    localparam int unsigned c_wait_states = 1;

    typedef enum logic [1:0] {
        MODE_NOP   = 2'd0,
        MODE_READ  = 2'd1,
        MODE_WRITE = 2'd2,
        MODE_RSVD  = 2'd3
    } bus_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        WAIT    = 2'd2,
        RESP    = 2'd3
    } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/simple_bus_if.sv
//============================================================================
// Module : simple_bus_if
// Brief  : simple_bus signal bundle with master and slave views.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

interface simple_bus_if
    import simple_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = c_addr_w,
    parameter int unsigned DATA_W = c_data_w
);

    logic              req;
    logic              gnt;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              data_oe;
    logic              rdy;
    logic              err;

    modport master (
        output req, start, addr, mode, data_i,
        input  gnt, data_o, data_oe, rdy, err
    );

    modport slave (
        input  req, start, addr, mode, data_i,
        output gnt, data_o, data_oe, rdy, err
    );

endinterface

`default_nettype wire

// File: rtl/simple_bus_resp_mem.sv
//============================================================================
// Module : simple_bus_resp_mem
// Brief  : Register-file memory, synchronous write/clear, combinational read.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module simple_bus_resp_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]  i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/simple_bus_responder.sv
//============================================================================
// Module : simple_bus_responder
// Brief  : simple_bus slave endpoint: grant FSM, wait states, local memory.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module simple_bus_responder
    import simple_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = c_addr_w,
    parameter int unsigned DATA_W      = c_data_w,
    parameter int unsigned DEPTH       = c_depth,
    parameter int unsigned WAIT_STATES = c_wait_states
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    simple_bus_if.slave  bus
);

    localparam int unsigned        c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_depth_ext = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]         c_ws_m1     = 4'(WAIT_STATES - 1);

    resp_state_e       r_state, w_state_nxt;
    logic [3:0]        r_wait, w_wait_nxt;
    logic              w_accept;

    logic [ADDR_W-1:0] r_addr;
    bus_mode_e         r_mode;
    logic [DATA_W-1:0] r_wdata;

    logic [ADDR_W-1:0] w_cmd_addr;
    bus_mode_e         w_cmd_mode;
    logic              w_bad;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    logic              w_rdy_nxt, w_err_nxt, w_oe_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    logic              r_gnt, r_rdy, r_err, r_data_oe;
    logic [DATA_W-1:0] r_data_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) w_state_nxt = GRANTED;
            end
            GRANTED: begin
                if (!bus.req) begin
                    w_state_nxt = IDLE;
                end else if (bus.start) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_wait_nxt  = c_ws_m1;
                    end
                end
            end
            WAIT: begin
                if (r_wait == 4'd0) w_state_nxt = RESP;
                else                w_wait_nxt  = r_wait - 4'd1;
            end
            RESP: begin
                w_state_nxt = bus.req ? GRANTED : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero wait states the response registers load on the accept edge,
    // before the latch holds the command, so they look at the live inputs.
    assign w_cmd_addr = w_accept ? bus.addr : r_addr;
    assign w_cmd_mode = w_accept ? bus_mode_e'(bus.mode) : r_mode;

    always_comb begin
        w_bad      = (w_cmd_mode == MODE_RSVD) || ({1'b0, w_cmd_addr} >= c_depth_ext);
        w_rdy_nxt  = (w_state_nxt == RESP);
        w_err_nxt  = w_rdy_nxt && w_bad;
        w_oe_nxt   = w_rdy_nxt && !w_bad && (w_cmd_mode == MODE_READ);
        w_data_nxt = w_oe_nxt ? w_rdata : '0;
        w_we       = (r_state == RESP) && (w_cmd_mode == MODE_WRITE) && !w_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt     <= 1'b0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_data_oe <= 1'b0;
            r_data_o  <= '0;
            r_addr    <= '0;
            r_mode    <= MODE_NOP;
            r_wdata   <= '0;
        end else begin
            r_gnt     <= (w_state_nxt != IDLE);
            r_rdy     <= w_rdy_nxt;
            r_err     <= w_err_nxt;
            r_data_oe <= w_oe_nxt;
            r_data_o  <= w_data_nxt;
            if (w_accept) begin
                r_addr  <= bus.addr;
                r_mode  <= bus_mode_e'(bus.mode);
                r_wdata <= bus.data_i;
            end
        end
    end

    simple_bus_resp_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (c_idx_w)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_addr[c_idx_w-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (w_cmd_addr[c_idx_w-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.gnt     = r_gnt;
    assign bus.rdy     = r_rdy;
    assign bus.err     = r_err;
    assign bus.data_oe = r_data_oe;
    assign bus.data_o  = r_data_o;

endmodule

`default_nettype wire
